// File: rtl/word_serializer_if.sv
// Word-in / byte-out handshake bundle for word_serializer.
// slave is the serializer's view; master is the view of the logic driving it.
interface word_serializer_if;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned BYTE_W = 8;

    logic              i_word_valid;
    logic [WORD_W-1:0] i_word_data;
    logic              o_word_ready;
    logic              o_byte_valid;
    logic [BYTE_W-1:0] o_byte_data;
    logic              o_byte_last;
    logic              i_byte_ready;

    modport slave (
        input  i_word_valid,
        input  i_word_data,
        input  i_byte_ready,
        output o_word_ready,
        output o_byte_valid,
        output o_byte_data,
        output o_byte_last
    );

    modport master (
        output i_word_valid,
        output i_word_data,
        output i_byte_ready,
        input  o_word_ready,
        input  o_byte_valid,
        input  o_byte_data,
        input  o_byte_last
    );
endinterface

// File: rtl/word_serializer.sv
// Serializes 64-bit words into 8-bit bytes and flags the last byte of each block.
// Optional XOR checksum trailer per block: define WORD_SERIALIZER_CHECKSUM_EN.
module word_serializer #(
    parameter int unsigned BLOCK_WORDS = 64,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    word_serializer_if.slave   bus
);
    localparam int unsigned WORD_W = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(7);
    localparam logic [IDX_W-1:0] PREV_BYTE = IDX_W'(6);
`ifdef WORD_SERIALIZER_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_EMPTY, S_SHIFT, S_CKSUM} state_t;

    state_t              state;
    logic [WORD_W-1:0]   hold;
    logic [IDX_W-1:0]    bidx;
    logic [CNT_W-1:0]    wcnt;
    logic                byte_valid;
    logic [BYTE_W-1:0]   byte_data;
    logic                byte_last;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;
`endif

    logic last_word;
    logic last_byte;
    logic cksum_pending;
    logic byte_hs;
    logic word_ready_c;

    function automatic logic [BYTE_W-1:0] pick(input logic [WORD_W-1:0] w,
                                               input logic [IDX_W-1:0]  i);
        if (MSB_FIRST)
            return w[8*(7-int'(i)) +: 8];
        else
            return w[8*int'(i) +: 8];
    endfunction

    assign last_word     = (wcnt == LAST_WORD);
    assign last_byte     = (bidx == LAST_BYTE);
    assign cksum_pending = CKSUM_EN & last_word;
    assign byte_hs       = byte_valid & bus.i_byte_ready;

    // Word accept looks through to i_byte_ready so words stream with no bubble.
    always_comb begin
        word_ready_c = 1'b0;
        if (sys_rst_n) begin
            if (state == S_EMPTY)
                word_ready_c = 1'b1;
            else if (state == S_SHIFT && last_byte && bus.i_byte_ready && !cksum_pending)
                word_ready_c = 1'b1;
        end
    end

    assign bus.o_word_ready = word_ready_c;
    assign bus.o_byte_valid = byte_valid;
    assign bus.o_byte_data  = byte_data;
    assign bus.o_byte_last  = byte_last;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_EMPTY;
            hold       <= '0;
            bidx       <= '0;
            wcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_last  <= 1'b0;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                S_EMPTY: begin
                    if (bus.i_word_valid) begin
                        hold       <= bus.i_word_data;
                        bidx       <= '0;
                        byte_data  <= pick(bus.i_word_data, '0);
                        byte_valid <= 1'b1;
                        byte_last  <= 1'b0;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (byte_hs) begin
`ifdef WORD_SERIALIZER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (!last_byte) begin
                            bidx      <= bidx + IDX_W'(1);
                            byte_data <= pick(hold, bidx + IDX_W'(1));
                            byte_last <= !CKSUM_EN && (bidx == PREV_BYTE) && last_word;
                        end else begin
                            wcnt <= last_word ? '0 : wcnt + CNT_W'(1);
                            if (cksum_pending) begin
                                // Trailer carries the XOR including the byte just sent.
`ifdef WORD_SERIALIZER_CHECKSUM_EN
                                byte_data <= csum ^ byte_data;
`endif
                                byte_last <= 1'b1;
                                state     <= S_CKSUM;
                            end else if (bus.i_word_valid) begin
                                hold      <= bus.i_word_data;
                                bidx      <= '0;
                                byte_data <= pick(bus.i_word_data, '0);
                                byte_last <= 1'b0;
                            end else begin
                                byte_valid <= 1'b0;
                                byte_last  <= 1'b0;
                                state      <= S_EMPTY;
                            end
                        end
                    end
                end
`ifdef WORD_SERIALIZER_CHECKSUM_EN
                S_CKSUM: begin
                    if (byte_hs) begin
                        csum       <= '0;
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        state      <= S_EMPTY;
                    end
                end
`endif
                default: state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: doc/word_serializer.md
# word_serializer

Downstream consumer of the 64-bit ping-pong buffer output. Accepts 64-bit words over a valid/ready handshake and emits them as a stream of 8-bit bytes over a second valid/ready handshake. Tracks block boundaries of one bank of words, marks the last byte of each block, and can optionally append an XOR checksum byte per block. It sits between the ping-pong buffer's downstream port and the byte-wide transmit logic.

## Interface

Parameters:
- `BLOCK_WORDS`, default 64: words per block, equal to one ping-pong bank depth; legal range 2..64.
- `MSB_FIRST`, default 1: 1 = byte 0 is data[63:56]; 0 = byte 0 is data[7:0].

Ports:
- `sys_clk` input 1: single clock, 50 MHz.
- `sys_rst_n` input 1: reset, asynchronous, active-low.
- `i_word_valid` input 1: upstream word valid; connect to the ping-pong buffer's `o_downstream_valid`.
- `i_word_data` input 64: upstream word; connect to the buffer's `data_out`.
- `o_word_ready` output 1: word accept; connect to the buffer's `i_downstream_ready`.
- `o_byte_valid` output 1: byte valid.
- `o_byte_data` output 8: byte data.
- `o_byte_last` output 1: marks the final byte of a block; qualified by `o_byte_valid`.
- `i_byte_ready` input 1: downstream byte ready.

## Operation

- Datapath:
  - 64-bit holding register.
  - 3-bit byte index `bidx`.
  - 6-bit word counter `wcnt`.
  - 8-bit running checksum `csum` (macro only).
- State machine:
  - EMPTY: no word held. `o_word_ready`=1, `o_byte_valid`=0. On a word handshake: latch the word, set `bidx`=0, go to SHIFT.
  - SHIFT: `o_byte_valid`=1. `o_byte_data` is the byte selected by `bidx` and `MSB_FIRST`. Each byte handshake increments `bidx`.
  - SHIFT, on the handshake with `bidx`=7:
    - If `wcnt`=BLOCK_WORDS-1 and CHECKSUM_EN is defined, go to CKSUM.
    - Otherwise, if `i_word_valid`=1, latch the next word and stay in SHIFT with `bidx`=0.
    - Otherwise, go to EMPTY.
  - CKSUM (macro only): `o_byte_valid`=1, `o_byte_data`=`csum`, `o_byte_last`=1. On the handshake: clear `csum`, go to EMPTY.
- `o_word_ready` = (state==EMPTY) | (state==SHIFT & `bidx`==7 & `i_byte_ready` & no pending CKSUM). This is a combinational path from `i_byte_ready`; it allows back-to-back words with no bubble.
- `wcnt` increments on the handshake of the last data byte of each word. It wraps BLOCK_WORDS-1 → 0.
- `o_byte_last` without the macro: asserted on byte `bidx`=7 of the word with `wcnt`=BLOCK_WORDS-1.
- `csum`: XOR of every data byte transferred in the current block, updated on each data-byte handshake.
- Stall rule: while `o_byte_valid`=1 and `i_byte_ready`=0, `o_byte_data` and `o_byte_last` hold stable and valid is not withdrawn.
- `i_word_data` is sampled only on a word handshake (`i_word_valid` & `o_word_ready`).
- Reset (asynchronous, any time, including mid-word or mid-block):
  - State → EMPTY; `bidx`, `wcnt` and `csum` → 0; the held word is discarded.
  - Outputs: `o_byte_valid`=0, `o_byte_data`=8'h00, `o_byte_last`=0.
  - `o_word_ready` is forced 0 while `sys_rst_n`=0, and is 1 on the first clock after release.

## Timing

- Latency: word handshake at edge N → byte 0 valid from cycle N+1.
- Throughput with the downstream always ready:
  - one byte per cycle;
  - one word per 8 cycles, no bubble between words;
  - a block takes 8·BLOCK_WORDS cycles, +1 with CHECKSUM_EN.
- After CKSUM, the next word is accepted from EMPTY. This costs one idle cycle per block.
- Simultaneous last-byte handshake and new word valid: the new word is latched at the same edge.

## Configuration

- `WORD_SERIALIZER_CHECKSUM_EN` defined:
  - CKSUM state, `csum` register and trailer byte are compiled in.
  - `o_byte_last` marks the checksum byte.
- Not defined:
  - no trailer byte and no `csum` logic;
  - `o_byte_last` marks byte 7 of the final word of the block.

## Test plan

- Single word, `MSB_FIRST`=1, `i_byte_ready` held 1: word 0x0102030405060708 → bytes 01,02,...,08 on 8 consecutive cycles starting the cycle after the handshake; `o_word_ready`=0 during bytes 01..07.
- Back-to-back words, `MSB_FIRST`=0: words 0x0102030405060708 then 0x1112131415161718 → 08..01 then 18..11 with no gap; second word accepted on the edge that transfers byte 01.
- Backpressure: drop `i_byte_ready` for 5 cycles while byte 03 is presented → 03 held stable with valid high; sequence resumes with 04; no byte lost or duplicated.
- Block boundary, `BLOCK_WORDS`=2, macro off → `o_byte_last`=1 only on the 16th byte; `wcnt` back to 0.
- Checksum, `BLOCK_WORDS`=2, macro on: words 0x0102030405060708 and 0x00000000000000FF → 17th byte = 0xF7 with `o_byte_last`=1.
- Reset during byte 5 of a word → outputs 0 immediately; after release `o_word_ready`=1; next word serializes from byte 0 with `wcnt`=0.
